// File: rtl/sw_handshake_port.sv
// CPU-side end of the DE0 switch/LED handshake.
// Synchronises the switch byte and strobe into clk, debounces the strobe,
// runs the strobe-high / consume / strobe-low handshake and holds the LED register.
module sw_handshake_port #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_strobe,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  input  logic              in_ack,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] LED,
  output logic [1:0]        hs_state
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    HOLD    = 2'd1,
    WAIT_LO = 2'd2
  } hs_state_t;

  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
  logic                   strobe_s;
  logic [DATA_W-1:0]      data_s;

  logic [CNT_W-1:0]       db_cnt;
  logic                   db_s;

  hs_state_t              state_q;
  hs_state_t              state_d;
  logic                   valid_d;
  logic [DATA_W-1:0]      data_d;

  // Multi-flop synchronisers for the strobe and each data bit; data is not debounced.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      strobe_sync <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        data_sync[i] <= '0;
      end
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], sw_strobe};
      data_sync[0] <= sw_data;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign strobe_s = strobe_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive differing synced samples.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      db_cnt <= '0;
      db_s   <= 1'b0;
    end else if (strobe_s == db_s) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_s   <= strobe_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Handshake next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = in_valid;
    data_d  = in_data;
    unique case (state_q)
      WAIT_HI: begin
        if (db_s) begin
          data_d  = data_s;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Byte stays frozen here regardless of switch or strobe activity.
        if (in_ack) begin
          valid_d = 1'b0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!db_s) begin
          state_d = WAIT_HI;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = WAIT_HI;
      end
    endcase
  end

  // Handshake state and registered CPU-facing outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= WAIT_HI;
      in_valid <= 1'b0;
      in_data  <= '0;
    end else begin
      state_q  <= state_d;
      in_valid <= valid_d;
      in_data  <= data_d;
    end
  end

  assign hs_state = state_q;

  // CPU-written LED register, independent of the handshake.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      LED <= '0;
    end else if (out_we) begin
      LED <= out_data;
    end
  end

endmodule

// File: tb/tb_sw_handshake_port.sv
// Self-checking bench for sw_handshake_port: directed vector table, hand sequences
// for multi-cycle corners, and random stimulus against a delay-line/run-length model.
module tb_sw_handshake_port;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned DB     = 4;

  logic              clk = 1'b0;
  logic              nReset = 1'b0;
  logic [DATA_W-1:0] sw_data = '0;
  logic              sw_strobe = 1'b0;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ack = 1'b0;
  logic              out_we = 1'b0;
  logic [DATA_W-1:0] out_data = '0;
  logic [DATA_W-1:0] LED;
  logic [1:0]        hs_state;

  int total = 0;
  int bad   = 0;
  int nbytes = 0;
  logic prev_valid = 1'b0;

  sw_handshake_port #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .nReset(nReset), .sw_data(sw_data), .sw_strobe(sw_strobe),
    .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
    .out_we(out_we), .out_data(out_data), .LED(LED), .hs_state(hs_state)
  );

  always #5 clk = ~clk;

  // Reference model: raw inputs seen SYNC edges late, strobe flips after a run
  // of DB samples all differing from the current debounced level.
  bit              m_s_line[$];
  logic [7:0]      m_d_line[$];
  bit              m_win[$];
  bit              m_db;
  int              m_state;
  bit              m_valid;
  logic [7:0]      m_data;
  logic [7:0]      m_led;
  bit              mchk = 1'b0;

  function automatic void model_reset();
    m_s_line = {}; m_d_line = {}; m_win = {};
    for (int i = 0; i < int'(SYNC); i++) begin m_s_line.push_back(1'b0); m_d_line.push_back(8'h00); end
    for (int i = 0; i < int'(DB); i++) m_win.push_back(1'b0);
    m_db = 1'b0; m_state = 0; m_valid = 1'b0; m_data = 8'h00; m_led = 8'h00;
  endfunction

  function automatic void model_edge();
    bit syn_s;
    logic [7:0] syn_d;
    bit all_diff;
    if (!nReset) begin
      model_reset();
      return;
    end
    syn_s = m_s_line[0];
    syn_d = m_d_line[0];
    case (m_state)
      0: if (m_db) begin m_data = syn_d; m_valid = 1'b1; m_state = 1; end
      1: if (in_ack) begin m_valid = 1'b0; m_state = 2; end
      default: if (!m_db) m_state = 0;
    endcase
    if (out_we) m_led = out_data;
    m_win.push_back(syn_s);
    void'(m_win.pop_front());
    all_diff = 1'b1;
    foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 1'b0;
    if (all_diff) m_db = !m_db;
    m_s_line.push_back(sw_strobe); void'(m_s_line.pop_front());
    m_d_line.push_back(sw_data);   void'(m_d_line.pop_front());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: model advances on the edge, DUT sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (in_valid && !prev_valid) nbytes++;
    prev_valid = in_valid;
    if (mchk) begin
      chk("m_valid", 32'(in_valid), 32'(m_valid));
      chk("m_data",  32'(in_data),  32'(m_data));
      chk("m_state", 32'(hs_state), 32'(m_state));
      chk("m_led",   32'(LED),      32'(m_led));
    end
  endtask

  task automatic set_sw(input logic [8:0] sw);
    sw_strobe = sw[8];
    sw_data   = sw[7:0];
  endtask

  typedef struct {
    logic       nrst;
    logic [8:0] sw;
    logic       ack;
    logic       we;
    logic [7:0] od;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] es;
    logic [7:0] el;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic nrst, input logic [8:0] sw, input logic ack,
                              input logic we, input logic [7:0] od, input logic ev,
                              input logic [7:0] ed, input logic [1:0] es, input logic [7:0] el);
    vec_t v;
    v.nrst = nrst; v.sw = sw; v.ack = ack; v.we = we; v.od = od;
    v.ev = ev; v.ed = ed; v.es = es; v.el = el;
    vt.push_back(v);
  endfunction

  initial begin
    int b0;
    model_reset();

    // reset held with all switches up, then release
    add(0, 9'h1FF, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);
    add(0, 9'h1FF, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);
    add(1, 9'h000, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);
    // handshake: valid on the 7th edge after strobe is first sampled
    for (int i = 0; i < 6; i++) add(1, 9'h1A5, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);
    add(1, 9'h1A5, 0, 0, 8'h00, 1, 8'hA5, 2'd1, 8'h00);
    add(1, 9'h1A5, 1, 0, 8'h00, 0, 8'hA5, 2'd2, 8'h00);
    add(1, 9'h1A5, 0, 0, 8'h00, 0, 8'hA5, 2'd2, 8'h00);
    for (int i = 0; i < 6; i++) add(1, 9'h000, 0, 0, 8'h00, 0, 8'hA5, 2'd2, 8'h00);
    add(1, 9'h000, 0, 0, 8'h00, 0, 8'hA5, 2'd0, 8'h00);
    // LED write and hold
    add(1, 9'h000, 0, 1, 8'h5A, 0, 8'hA5, 2'd0, 8'h5A);
    add(1, 9'h000, 0, 0, 8'hFF, 0, 8'hA5, 2'd0, 8'h5A);
    // enter HOLD, then reset discards byte and clears LED
    for (int i = 0; i < 6; i++) add(1, 9'h1C3, 0, 0, 8'h00, 0, 8'hA5, 2'd0, 8'h5A);
    add(1, 9'h1C3, 0, 0, 8'h00, 1, 8'hC3, 2'd1, 8'h5A);
    add(0, 9'h1C3, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);
    add(1, 9'h000, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);
    // 3-cycle strobe glitch is rejected
    for (int i = 0; i < 3; i++) add(1, 9'h13C, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);
    for (int i = 0; i < 8; i++) add(1, 9'h000, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'h00);

    @(negedge clk);
    foreach (vt[k]) begin
      nReset = vt[k].nrst; set_sw(vt[k].sw);
      in_ack = vt[k].ack; out_we = vt[k].we; out_data = vt[k].od;
      tick();
      chk($sformatf("v%0d_valid", k), 32'(in_valid), 32'(vt[k].ev));
      chk($sformatf("v%0d_data", k),  32'(in_data),  32'(vt[k].ed));
      chk($sformatf("v%0d_state", k), 32'(hs_state), 32'(vt[k].es));
      chk($sformatf("v%0d_led", k),   32'(LED),      32'(vt[k].el));
    end
    in_ack = 1'b0; out_we = 1'b0;

    mchk = 1'b1;

    // early strobe release: byte frozen, WAIT_LO exits immediately, no second byte
    set_sw(9'h10F);
    repeat (7) tick();
    chk("t4_valid", 32'(in_valid), 32'd1);
    chk("t4_data", 32'(in_data), 32'h0F);
    set_sw(9'h0F0);
    repeat (10) tick();
    chk("t4_frozen_data", 32'(in_data), 32'h0F);
    chk("t4_hold_state", 32'(hs_state), 32'd1);
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    chk("t4_ack_state", 32'(hs_state), 32'd2);
    chk("t4_ack_valid", 32'(in_valid), 32'd0);
    tick();
    chk("t4_rearm_state", 32'(hs_state), 32'd0);
    b0 = nbytes;
    repeat (12) tick();
    chk("t4_no_second", 32'(nbytes - b0), 32'd0);

    // stray / held ack: no effect outside HOLD, one byte per strobe cycle
    set_sw(9'h000);
    in_ack = 1'b1;
    repeat (3) tick();
    chk("t5_stray_hi", 32'(hs_state), 32'd0);
    b0 = nbytes;
    set_sw(9'h155);
    repeat (7) tick();
    chk("t5_b1_valid", 32'(in_valid), 32'd1);
    chk("t5_b1_data", 32'(in_data), 32'h55);
    tick();
    chk("t5_b1_consumed", 32'(hs_state), 32'd2);
    repeat (3) tick();
    chk("t5_stray_lo", 32'(hs_state), 32'd2);
    set_sw(9'h000); repeat (8) tick();
    set_sw(9'h166); repeat (9) tick();
    set_sw(9'h000); repeat (9) tick();
    in_ack = 1'b0;
    chk("t5_two_bytes", 32'(nbytes - b0), 32'd2);
    chk("t5_b2_data", 32'(in_data), 32'h66);

    // random stimulus against the model
    for (int seg = 0; seg < 300; seg++) begin
      set_sw(9'($urandom));
      for (int c = 0; c < int'($urandom_range(1, 9)); c++) begin
        in_ack   = ($urandom % 4) == 0;
        out_we   = ($urandom % 5) == 0;
        out_data = 8'($urandom);
        nReset   = ($urandom % 200) != 0;
        tick();
        nReset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
